// File: rtl/fluorescence_pkg.sv
// Shared definitions for the fluorescence front-end slice.
//   pmt_state_t          : pulse-qualification FSM states
//   DEFAULT_COUNT_WIDTH  : default width of diagnostic counters
//   CLK_HZ               : system clock frequency (clock_50_mhz)
package fluorescence_pkg;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEFAULT_COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    DEAD    = 2'd2
  } pmt_state_t;

endpackage

// File: rtl/pmt_pulse_conditioner_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock_50_mhz : system clock
//   reset        : synchronous active-high reset, zeroes the count
//   inc          : count up by one (held at all-ones once saturated)
//   clear        : synchronous zero; wins over a coincident inc
//   count        : current value
module sat_counter
  import fluorescence_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clock_50_mhz,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] count
);

  always_ff @(posedge clock_50_mhz) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pmt_pulse_conditioner.sv
// PMT pulse conditioner: synchronises the raw discriminator output,
// rejects short glitches, applies non-paralyzable dead-time, tags each
// accepted photon with the modulation phase and suppresses photons close
// to light-source transitions.
//   clock_50_mhz      : system clock
//   reset             : synchronous active-high reset
//   pmt_in            : raw asynchronous discriminator output
//   light_source_flag : modulation phase (clock_50_mhz domain)
//   clear_counts      : synchronous clear of the four diagnostic counters
//   pulse_strobe      : one-cycle strobe per accepted photon
//   pulse_phase       : phase tag, valid with pulse_strobe, 0 otherwise
//   accepted_count    : strobes emitted
//   glitch_count      : edges rejected as too short
//   deadtime_count    : edges rejected during dead-time
//   blank_count       : qualified pulses suppressed by blanking
module pmt_pulse_conditioner
  import fluorescence_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_WIDTH   = 2,
  parameter int unsigned DEAD_TIME   = 10,
  parameter int unsigned EDGE_BLANK  = 25,
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clock_50_mhz,
  input  logic                   reset,
  input  logic                   pmt_in,
  input  logic                   light_source_flag,
  input  logic                   clear_counts,
  output logic                   pulse_strobe,
  output logic                   pulse_phase,
  output logic [COUNT_WIDTH-1:0] accepted_count,
  output logic [COUNT_WIDTH-1:0] glitch_count,
  output logic [COUNT_WIDTH-1:0] deadtime_count,
  output logic [COUNT_WIDTH-1:0] blank_count
);

  localparam int unsigned WIDTH_W = $clog2(MIN_WIDTH + 1);
  localparam int unsigned DEAD_W  = $clog2(DEAD_TIME + 1);
  localparam int unsigned BLANK_W = $clog2(EDGE_BLANK + 2);

  localparam logic [WIDTH_W-1:0] MIN_L     = WIDTH_W'(MIN_WIDTH);
  localparam logic [DEAD_W-1:0]  DEAD_L    = DEAD_W'(DEAD_TIME);
  localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(EDGE_BLANK);

  // Synchroniser and edge detect
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_level;
  logic                   prev_level;
  logic                   pulse_edge;

  assign sync_level = sync_chain[SYNC_STAGES-1];
  assign pulse_edge = sync_level && !prev_level;

  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      sync_chain <= '0;
      prev_level <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], pmt_in};
      prev_level <= sync_level;
    end
  end

  // Blanking window: cycles since the last light-source transition,
  // saturating at EDGE_BLANK.
  logic               flag_prev;
  logic [BLANK_W-1:0] blank_cnt;
  logic               in_blank;

  assign in_blank = (blank_cnt < BLANK_MAX);

  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      flag_prev <= 1'b0;
      blank_cnt <= '0;
    end else begin
      flag_prev <= light_source_flag;
      if (light_source_flag != flag_prev) begin
        blank_cnt <= '0;
      end else if (blank_cnt < BLANK_MAX) begin
        blank_cnt <= blank_cnt + BLANK_W'(1);
      end
    end
  end

  // Qualification FSM
  pmt_state_t         state, state_next;
  logic [WIDTH_W-1:0] width_cnt, width_next;
  logic [DEAD_W-1:0]  dead_cnt, dead_next;
  logic               tag_q, tag_next;
  logic               blanked_q, blanked_next;
  logic               strobe_next, phase_next;
  logic               qualify, q_tag, q_blanked;
  logic               inc_accepted, inc_glitch, inc_deadtime, inc_blank;

  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      state        <= IDLE;
      width_cnt    <= '0;
      dead_cnt     <= '0;
      tag_q        <= 1'b0;
      blanked_q    <= 1'b0;
      pulse_strobe <= 1'b0;
      pulse_phase  <= 1'b0;
    end else begin
      state        <= state_next;
      width_cnt    <= width_next;
      dead_cnt     <= dead_next;
      tag_q        <= tag_next;
      blanked_q    <= blanked_next;
      pulse_strobe <= strobe_next;
      pulse_phase  <= phase_next;
    end
  end

  always_comb begin
    state_next   = state;
    width_next   = width_cnt;
    dead_next    = dead_cnt;
    tag_next     = tag_q;
    blanked_next = blanked_q;
    strobe_next  = 1'b0;
    phase_next   = 1'b0;
    qualify      = 1'b0;
    q_tag        = tag_q;
    q_blanked    = blanked_q;
    inc_accepted = 1'b0;
    inc_glitch   = 1'b0;
    inc_deadtime = 1'b0;
    inc_blank    = 1'b0;

    case (state)
      IDLE: begin
        if (pulse_edge) begin
          tag_next     = light_source_flag;
          blanked_next = in_blank;
          width_next   = WIDTH_W'(1);
          // With MIN_WIDTH=1 the edge cycle itself qualifies, so the
          // capture must bypass the tag/blank registers.
          if (MIN_WIDTH == 1) begin
            qualify   = 1'b1;
            q_tag     = light_source_flag;
            q_blanked = in_blank;
          end else begin
            state_next = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (!sync_level) begin
          inc_glitch = 1'b1;
          state_next = IDLE;
        end else if ((width_cnt + WIDTH_W'(1)) == MIN_L) begin
          qualify = 1'b1;
        end else begin
          width_next = width_cnt + WIDTH_W'(1);
        end
      end
      DEAD: begin
        if (pulse_edge) begin
          inc_deadtime = 1'b1;
        end
        if (dead_cnt == DEAD_L) begin
          state_next = IDLE;
        end else begin
          dead_next = dead_cnt + DEAD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (qualify) begin
      state_next = DEAD;
      dead_next  = '0;
      if (q_blanked) begin
        inc_blank = 1'b1;
      end else begin
        strobe_next  = 1'b1;
        phase_next   = q_tag;
        inc_accepted = 1'b1;
      end
    end
  end

  // Diagnostic counters
  sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_accepted_count (
    .clock_50_mhz (clock_50_mhz),
    .reset        (reset),
    .inc          (inc_accepted),
    .clear        (clear_counts),
    .count        (accepted_count)
  );

  sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_glitch_count (
    .clock_50_mhz (clock_50_mhz),
    .reset        (reset),
    .inc          (inc_glitch),
    .clear        (clear_counts),
    .count        (glitch_count)
  );

  sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_deadtime_count (
    .clock_50_mhz (clock_50_mhz),
    .reset        (reset),
    .inc          (inc_deadtime),
    .clear        (clear_counts),
    .count        (deadtime_count)
  );

  sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_blank_count (
    .clock_50_mhz (clock_50_mhz),
    .reset        (reset),
    .inc          (inc_blank),
    .clear        (clear_counts),
    .count        (blank_count)
  );

endmodule

// File: tb/tb_pmt_pulse_conditioner.sv
// Bench for pmt_pulse_conditioner. Two instances share all inputs:
// dut_a (EDGE_BLANK=0, COUNT_WIDTH=4) and dut_b (EDGE_BLANK=25, COUNT_WIDTH=32).
// A reference model works from recorded input samples: it derives the
// synchronised level by delay, finds rising edges, and applies the
// run-length, dead-window and blank-window rules per edge.
module tb_pmt_pulse_conditioner;
  import fluorescence_pkg::*;

  localparam int SYNC = 2;
  localparam int MW   = 2;
  localparam int DT   = 10;
  localparam int EB_A = 0;
  localparam int EB_B = 25;
  localparam int CW_A = 4;
  localparam int CW_B = 32;
  localparam int MAXC = 16384;

  logic clock_50_mhz = 1'b0;
  logic reset = 1'b1;
  logic pmt_in = 1'b0;
  logic light_source_flag = 1'b0;
  logic clear_counts = 1'b0;

  logic            a_strobe, a_phase;
  logic [CW_A-1:0] a_acc, a_glitch, a_dead, a_blank;
  logic            b_strobe, b_phase;
  logic [CW_B-1:0] b_acc, b_glitch, b_dead, b_blank;

  always #10 clock_50_mhz = ~clock_50_mhz;

  pmt_pulse_conditioner #(
    .SYNC_STAGES (SYNC), .MIN_WIDTH (MW), .DEAD_TIME (DT),
    .EDGE_BLANK  (EB_A), .COUNT_WIDTH (CW_A)
  ) dut_a (
    .clock_50_mhz (clock_50_mhz), .reset (reset), .pmt_in (pmt_in),
    .light_source_flag (light_source_flag), .clear_counts (clear_counts),
    .pulse_strobe (a_strobe), .pulse_phase (a_phase),
    .accepted_count (a_acc), .glitch_count (a_glitch),
    .deadtime_count (a_dead), .blank_count (a_blank)
  );

  pmt_pulse_conditioner #(
    .SYNC_STAGES (SYNC), .MIN_WIDTH (MW), .DEAD_TIME (DT),
    .EDGE_BLANK  (EB_B), .COUNT_WIDTH (CW_B)
  ) dut_b (
    .clock_50_mhz (clock_50_mhz), .reset (reset), .pmt_in (pmt_in),
    .light_source_flag (light_source_flag), .clear_counts (clear_counts),
    .pulse_strobe (b_strobe), .pulse_phase (b_phase),
    .accepted_count (b_acc), .glitch_count (b_glitch),
    .deadtime_count (b_dead), .blank_count (b_blank)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  bit     pmt_s[MAXC], flag_s[MAXC], rst_s[MAXC], clr_s[MAXC];
  int     cyc = 0;
  longint e_acc[2], e_gl[2], e_dt[2], e_bl[2];
  bit     e_strobe[2], e_phase[2];
  bit     pend[2], ptag[2], pbl[2], have_q[2];
  int     pe[2], q_e[2], zero_cyc[2];
  int     mism[2], first_mism[2], obs_cnt[2];
  bit     last_ph[2];
  bit     model_on = 1'b0;

  // Synchronised level during cycle c: the pmt_in sample SYNC-1 edges
  // earlier, unless a reset landed inside that window.
  function automatic bit lvl(int c);
    if (c < SYNC) return 1'b0;
    for (int k = c - SYNC + 1; k <= c; k++) if (rst_s[k]) return 1'b0;
    return pmt_s[c - SYNC + 1];
  endfunction

  function automatic longint bump(longint v, int cw);
    longint mx;
    mx = (longint'(1) << cw) - 1;
    return (v < mx) ? v + 1 : v;
  endfunction

  // Settles cycle c = n-1 (its inputs are the samples taken at edge n)
  // and yields the expected outputs visible during cycle n.
  task automatic model_step(int n);
    int c, bc, eb, cw;
    bit f, fp, l, lp, edge_c;
    c      = n - 1;
    f      = flag_s[n];
    fp     = rst_s[c] ? 1'b0 : flag_s[c];
    l      = lvl(c);
    lp     = lvl(c - 1);
    edge_c = l && !lp;
    for (int i = 0; i < 2; i++) begin
      eb = (i == 0) ? EB_A : EB_B;
      cw = (i == 0) ? CW_A : CW_B;
      e_strobe[i] = 1'b0;
      e_phase[i]  = 1'b0;
      if (rst_s[n]) begin
        e_acc[i] = 0; e_gl[i] = 0; e_dt[i] = 0; e_bl[i] = 0;
        pend[i] = 1'b0; have_q[i] = 1'b0; zero_cyc[i] = n;
        continue;
      end
      bc = c - zero_cyc[i];
      if (bc > eb) bc = eb;
      if (edge_c) begin
        if (have_q[i] && (c <= q_e[i] + MW + DT)) begin
          e_dt[i] = bump(e_dt[i], cw);
        end else begin
          pend[i] = 1'b1; pe[i] = c; ptag[i] = f; pbl[i] = (bc < eb);
        end
      end
      if (pend[i]) begin
        if (!l) begin
          e_gl[i] = bump(e_gl[i], cw);
          pend[i] = 1'b0;
        end else if (c - pe[i] + 1 == MW) begin
          if (pbl[i]) begin
            e_bl[i] = bump(e_bl[i], cw);
          end else begin
            e_acc[i] = bump(e_acc[i], cw);
            e_strobe[i] = 1'b1;
            e_phase[i] = ptag[i];
          end
          have_q[i] = 1'b1; q_e[i] = pe[i]; pend[i] = 1'b0;
        end
      end
      if (f != fp) zero_cyc[i] = n;
      if (clr_s[n]) begin
        e_acc[i] = 0; e_gl[i] = 0; e_dt[i] = 0; e_bl[i] = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clock_50_mhz);
      cyc++;
      if (cyc < MAXC) begin
        pmt_s[cyc] = pmt_in; flag_s[cyc] = light_source_flag;
        rst_s[cyc] = reset;  clr_s[cyc] = clear_counts;
        model_step(cyc);
      end
      #1;
      if (cyc < MAXC && rst_s[cyc]) model_on = 1'b1;
      if (model_on) begin
        for (int i = 0; i < 2; i++) begin
          logic s, p;
          s = (i == 0) ? a_strobe : b_strobe;
          p = (i == 0) ? a_phase : b_phase;
          if (s !== e_strobe[i] || p !== e_phase[i]) begin
            if (mism[i] == 0) first_mism[i] = cyc;
            mism[i]++;
          end
          if (s === 1'b1) begin
            obs_cnt[i]++;
            last_ph[i] = p;
          end
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clock_50_mhz);
  endtask

  task automatic pulse(input int hi);
    pmt_in = 1'b1;
    tick(hi);
    pmt_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pmt_in = 1'b0; light_source_flag = 1'b0; clear_counts = 1'b0;
    tick(4);
    n_total++;
    if ({a_strobe, a_phase, a_acc, a_glitch, a_dead, a_blank} !== '0)
      $display("FAIL reset_a: got %0h expected 0", {a_strobe, a_phase, a_acc, a_glitch, a_dead, a_blank});
    else n_pass++;
    n_total++;
    if ({b_strobe, b_phase, b_acc, b_glitch, b_dead, b_blank} !== '0)
      $display("FAIL reset_b: got %0h expected 0", {b_strobe, b_phase, b_acc, b_glitch, b_dead, b_blank});
    else n_pass++;
    n_total++;
    if (dut_a.state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dut_a.state, IDLE);
    else n_pass++;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_single_pulse();
    int lat, s0;
    logic ph;
    lat = -1; ph = 1'b0;
    light_source_flag = 1'b1;
    tick(3);
    s0 = obs_cnt[0];
    pmt_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 5) pmt_in = 1'b0;
      if (a_strobe === 1'b1 && lat < 0) begin lat = k; ph = a_phase; end
    end
    n_total++;
    if (lat != SYNC + MW) $display("FAIL single_latency: got %0d expected %0d", lat, SYNC + MW);
    else n_pass++;
    n_total++;
    if (ph !== 1'b1) $display("FAIL single_phase: got %0b expected 1", ph);
    else n_pass++;
    n_total++;
    if (obs_cnt[0] - s0 != 1) $display("FAIL single_strobes: got %0d expected 1", obs_cnt[0] - s0);
    else n_pass++;
    n_total++;
    if (a_acc !== 4'd1) $display("FAIL single_accepted: got %0d expected 1", a_acc);
    else n_pass++;
    tick(15);
  endtask

  task automatic test_glitch();
    int g0, s0;
    g0 = int'(a_glitch); s0 = obs_cnt[0];
    pulse(1);
    tick(8);
    n_total++;
    if (a_glitch !== 4'(g0 + 1)) $display("FAIL glitch_count: got %0d expected %0d", a_glitch, g0 + 1);
    else n_pass++;
    n_total++;
    if (obs_cnt[0] != s0) $display("FAIL glitch_strobe: got %0d expected %0d", obs_cnt[0], s0);
    else n_pass++;
    n_total++;
    if (dut_a.state !== IDLE) $display("FAIL glitch_state: got %0d expected %0d", dut_a.state, IDLE);
    else n_pass++;
  endtask

  task automatic test_deadtime();
    int d0, s0;
    d0 = int'(a_dead); s0 = obs_cnt[0];
    pulse(3); tick(3); pulse(3); tick(20);
    n_total++;
    if (obs_cnt[0] - s0 != 1) $display("FAIL dead_close_strobes: got %0d expected 1", obs_cnt[0] - s0);
    else n_pass++;
    n_total++;
    if (a_dead !== 4'(d0 + 1)) $display("FAIL dead_close_count: got %0d expected %0d", a_dead, d0 + 1);
    else n_pass++;
    d0 = int'(a_dead); s0 = obs_cnt[0];
    pulse(3); tick(11); pulse(3); tick(20);
    n_total++;
    if (obs_cnt[0] - s0 != 2) $display("FAIL dead_far_strobes: got %0d expected 2", obs_cnt[0] - s0);
    else n_pass++;
    n_total++;
    if (a_dead !== 4'(d0)) $display("FAIL dead_far_count: got %0d expected %0d", a_dead, d0);
    else n_pass++;
  endtask

  task automatic test_blanking();
    int s0;
    logic [CW_B-1:0] bl0;
    logic newf;
    s0 = obs_cnt[1]; bl0 = b_blank;
    light_source_flag = ~light_source_flag;
    tick(8); pulse(3); tick(20);
    n_total++;
    if (obs_cnt[1] != s0) $display("FAIL blank_near_strobe: got %0d expected %0d", obs_cnt[1], s0);
    else n_pass++;
    n_total++;
    if (b_blank !== bl0 + 1) $display("FAIL blank_near_count: got %0d expected %0d", b_blank, bl0 + 1);
    else n_pass++;
    s0 = obs_cnt[1];
    light_source_flag = ~light_source_flag;
    newf = light_source_flag;
    tick(28); pulse(3); tick(10);
    n_total++;
    if (obs_cnt[1] - s0 != 1) $display("FAIL blank_far_strobe: got %0d expected 1", obs_cnt[1] - s0);
    else n_pass++;
    n_total++;
    if (last_ph[1] !== newf) $display("FAIL blank_far_phase: got %0b expected %0b", last_ph[1], newf);
    else n_pass++;
  endtask

  task automatic test_phase_capture();
    logic ph;
    bit seen;
    seen = 1'b0; ph = 1'b1;
    light_source_flag = 1'b0;
    tick(5);
    pmt_in = 1'b1;
    tick(3);
    light_source_flag = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (k == 2) pmt_in = 1'b0;
      if (a_strobe === 1'b1 && !seen) begin seen = 1'b1; ph = a_phase; end
    end
    n_total++;
    if (!seen || ph !== 1'b0) $display("FAIL phase_capture: got seen=%0b phase=%0b expected seen=1 phase=0", seen, ph);
    else n_pass++;
    tick(15);
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 20; p++) begin
      pulse(3);
      tick(13);
    end
    n_total++;
    if (a_acc !== 4'hF) $display("FAIL sat_accepted: got %0d expected 15", a_acc);
    else n_pass++;
    pmt_in = 1'b1;
    tick(3);
    clear_counts = 1'b1;
    tick(1);
    clear_counts = 1'b0;
    n_total++;
    if (a_strobe !== 1'b1) $display("FAIL clear_strobe: got %0b expected 1", a_strobe);
    else n_pass++;
    n_total++;
    if (a_acc !== 4'd0) $display("FAIL clear_priority: got %0d expected 0", a_acc);
    else n_pass++;
    tick(2);
    pmt_in = 1'b0;
    tick(15);
  endtask

  task automatic test_reset_mid_qualify();
    int s0;
    s0 = obs_cnt[0];
    pmt_in = 1'b1;
    tick(3);
    n_total++;
    if (dut_a.state !== QUALIFY) $display("FAIL midq_state: got %0d expected %0d", dut_a.state, QUALIFY);
    else n_pass++;
    reset = 1'b1;
    pmt_in = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(12);
    n_total++;
    if (obs_cnt[0] != s0) $display("FAIL midq_strobe: got %0d expected %0d", obs_cnt[0], s0);
    else n_pass++;
    n_total++;
    if (a_acc !== 4'd0) $display("FAIL midq_accepted: got %0d expected 0", a_acc);
    else n_pass++;
  endtask

  task automatic test_random();
    int r;
    for (int p = 0; p < 150; p++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) light_source_flag = ~light_source_flag;
      if (r == 9) clear_counts = 1'b1;
      pmt_in = 1'b1;
      tick(int'($urandom_range(1, 4)));
      clear_counts = 1'b0;
      pmt_in = 1'b0;
      tick(int'($urandom_range(1, 14)));
    end
    tick(20);
    n_total++;
    if (a_acc !== 4'(e_acc[0])) $display("FAIL rand_a_acc: got %0d expected %0d", a_acc, e_acc[0]);
    else n_pass++;
    n_total++;
    if (a_glitch !== 4'(e_gl[0])) $display("FAIL rand_a_glitch: got %0d expected %0d", a_glitch, e_gl[0]);
    else n_pass++;
    n_total++;
    if (a_dead !== 4'(e_dt[0])) $display("FAIL rand_a_dead: got %0d expected %0d", a_dead, e_dt[0]);
    else n_pass++;
    n_total++;
    if (a_blank !== 4'(e_bl[0])) $display("FAIL rand_a_blank: got %0d expected %0d", a_blank, e_bl[0]);
    else n_pass++;
    n_total++;
    if (b_acc !== 32'(e_acc[1])) $display("FAIL rand_b_acc: got %0d expected %0d", b_acc, e_acc[1]);
    else n_pass++;
    n_total++;
    if (b_glitch !== 32'(e_gl[1])) $display("FAIL rand_b_glitch: got %0d expected %0d", b_glitch, e_gl[1]);
    else n_pass++;
    n_total++;
    if (b_dead !== 32'(e_dt[1])) $display("FAIL rand_b_dead: got %0d expected %0d", b_dead, e_dt[1]);
    else n_pass++;
    n_total++;
    if (b_blank !== 32'(e_bl[1])) $display("FAIL rand_b_blank: got %0d expected %0d", b_blank, e_bl[1]);
    else n_pass++;
    n_total++;
    if (mism[0] != 0) $display("FAIL strobe_stream_a: got %0d mismatching cycles (first %0d) expected 0", mism[0], first_mism[0]);
    else n_pass++;
    n_total++;
    if (mism[1] != 0) $display("FAIL strobe_stream_b: got %0d mismatching cycles (first %0d) expected 0", mism[1], first_mism[1]);
    else n_pass++;
    n_total++;
    if (cyc >= MAXC) $display("FAIL model_capacity: got %0d cycles expected < %0d", cyc, MAXC);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_glitch();
    test_deadtime();
    test_blanking();
    test_phase_capture();
    test_saturation();
    test_reset_mid_qualify();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
